ac_motor_vf_ramp_control: RTL

//  Run sequencer for the SVPWM chain (sine sector -> vector time -> vector control -> switch control).

---
 rtl/ac_motor_pkg.sv | 22 ++
 rtl/ac_motor_vf_map.sv | 54 +++++
 rtl/ac_motor_vf_ramp_control.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ac_motor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ac_motor_pkg                                                     |
// | Shared state encoding and width defaults for the V/f ramp controller.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ac_motor_pkg;

  localparam int FREQ_W_DEF = 12;
  localparam int U_W_DEF    = 12;
  localparam logic [U_W_DEF-1:0] U_MAX = {U_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ac_motor_vf_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ac_motor_vf_map                                                  |
// | Registered V/f law: u = sat((f*VF_GAIN >> VF_SHIFT) + U_BOOST), gated.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ac_motor_vf_map
  import ac_motor_pkg::*;
#(
  parameter int FREQ_W   = FREQ_W_DEF,
  parameter int U_W      = U_W_DEF,
  parameter int VF_GAIN  = 8,
  parameter int VF_SHIFT = 3,
  parameter int U_BOOST  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] frequency_i,
  input  logic              enable_i,
  output logic [U_W-1:0]    u_str_o
);

  localparam int P_W = FREQ_W + 8;
  localparam int V_W = P_W + 1;
  localparam logic [V_W-1:0] U_SAT_V = {{(V_W-U_W){1'b0}}, {U_W{1'b1}}};

  logic [P_W-1:0] prod;
  logic [V_W-1:0] volt;
  logic [U_W-1:0] u_str_d;
  logic [U_W-1:0] u_str_q;

  assign prod = P_W'(frequency_i) * P_W'(VF_GAIN);
  assign volt = V_W'(prod >> VF_SHIFT) + V_W'(U_BOOST);

  // enable_i is the next-cycle gate, so u_str drops on the same edge as pwm_en
  always_comb begin
    u_str_d = '0;
    if (enable_i) begin
      u_str_d = (volt > U_SAT_V) ? {U_W{1'b1}} : volt[U_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_str_q <= '0;
    end else begin
      u_str_q <= u_str_d;
    end
  end

  assign u_str_o = u_str_q;

endmodule
`default_nettype wire

// File: rtl/ac_motor_vf_ramp_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ac_motor_vf_ramp_control                                         |
// | Run sequencer: slew-limited frequency ramp, V/f magnitude, fault latch.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ac_motor_vf_ramp_control
  import ac_motor_pkg::*;
#(
  parameter int FREQ_W   = FREQ_W_DEF,
  parameter int U_W      = U_W_DEF,
  parameter int RAMP_DIV = 1000,
  parameter int VF_GAIN  = 8,
  parameter int VF_SHIFT = 3,
  parameter int U_BOOST  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [FREQ_W-1:0] target_freq_i,
  input  logic              fault_in_i,
  input  logic              fault_clr_i,
  output logic [FREQ_W-1:0] frequency_o,
  output logic [U_W-1:0]    u_str_o,
  output logic              pwm_en_o,
  output logic              at_speed_o,
  output logic [2:0]        state_o
);

  localparam int PRESC_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(RAMP_DIV - 1);

  state_t              state_q,    state_d;
  logic [FREQ_W-1:0]   freq_q,     freq_d;
  logic [PRESC_W-1:0]  presc_q,    presc_d;
  logic                pwm_en_q,   pwm_en_d;
  logic                at_speed_q, at_speed_d;

  logic                tick;
  logic [PRESC_W-1:0]  presc_step;
  logic                tgt_zero;
  logic                start_ok;

  assign tick       = (presc_q == PRESC_MAX);
  assign presc_step = tick ? '0 : presc_q + PRESC_W'(1);
  assign tgt_zero   = (target_freq_i == '0);
  assign start_ok   = start_i && !stop_i && !tgt_zero;

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    presc_d    = '0;
    pwm_en_d   = pwm_en_q;
    at_speed_d = 1'b0;

    if (fault_in_i) begin
      state_d  = ST_FAULT;
      freq_d   = '0;
      pwm_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          freq_d   = '0;
          pwm_en_d = 1'b0;
          if (start_ok) begin
            state_d  = ST_RAMP;
            pwm_en_d = 1'b1;
          end
        end

        ST_RAMP: begin
          if (stop_i || tgt_zero) begin
            state_d = ST_STOP;
          end else begin
            presc_d = presc_step;
            if (tick) begin
              if (freq_q < target_freq_i) begin
                freq_d = freq_q + FREQ_W'(1);
              end else if (freq_q > target_freq_i) begin
                freq_d = freq_q - FREQ_W'(1);
              end
            end
            // Arrival (or a target moved onto the current value) ends the ramp
            if (freq_d == target_freq_i) begin
              state_d    = ST_RUN;
              at_speed_d = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (stop_i || tgt_zero) begin
            state_d = ST_STOP;
          end else if (target_freq_i != freq_q) begin
            state_d = ST_RAMP;
          end else begin
            at_speed_d = 1'b1;
          end
        end

        ST_STOP: begin
          if (start_ok) begin
            state_d = ST_RAMP;
          end else begin
            presc_d = presc_step;
            if (tick && (freq_q != '0)) begin
              freq_d = freq_q - FREQ_W'(1);
            end
            if (freq_d == '0) begin
              state_d  = ST_IDLE;
              pwm_en_d = 1'b0;
            end
          end
        end

        ST_FAULT: begin
          freq_d   = '0;
          pwm_en_d = 1'b0;
          if (fault_clr_i) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          freq_d   = '0;
          pwm_en_d = 1'b0;
        end
      endcase
    end

    if (state_d != state_q) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      freq_q     <= '0;
      presc_q    <= '0;
      pwm_en_q   <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      presc_q    <= presc_d;
      pwm_en_q   <= pwm_en_d;
      at_speed_q <= at_speed_d;
    end
  end

  ac_motor_vf_map #(
    .FREQ_W   (FREQ_W),
    .U_W      (U_W),
    .VF_GAIN  (VF_GAIN),
    .VF_SHIFT (VF_SHIFT),
    .U_BOOST  (U_BOOST)
  ) u_vf_map (
    .clk         (clk),
    .rst         (rst),
    .frequency_i (freq_q),
    .enable_i    (pwm_en_d),
    .u_str_o     (u_str_o)
  );

  assign frequency_o = freq_q;
  assign pwm_en_o    = pwm_en_q;
  assign at_speed_o  = at_speed_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire
